// File: rtl/area_select_pkg.sv
// area_select shared types: FSM state, default sizes,
// and the one-hot to index encoder used by the selector.
package area_select_pkg;

  localparam int N_BTN_DEF = 8;
  localparam int AW_DEF    = 3;

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  typedef struct packed {
    logic              ok;
    logic [AW_DEF-1:0] idx;
  } enc_t;

  // ok is set only for exactly one bit high; idx is
  // meaningful only when ok is set.
  function automatic enc_t onehot_enc(
    input logic [N_BTN_DEF-1:0] v
  );
    enc_t e;
    e.ok  = (v != '0) &&
            ((v & (v - N_BTN_DEF'(1))) == '0);
    e.idx = '0;
    for (int i = 0; i < N_BTN_DEF; i++) begin
      if (v[i]) begin
        e.idx = e.idx | AW_DEF'(i);
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/area_select_if.sv
// Button/area bundle: btn, finish in (master drives);
// area, switch strobe, multi level out (slave drives).
interface area_select_if
  import area_select_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF,
  parameter int AW    = AW_DEF
) ();

  logic [N_BTN-1:0] btn;
  logic             finish;
  logic [AW-1:0]    area;
  logic             switch;
  logic             multi;

  modport master (
    output btn,
    output finish,
    input  area,
    input  switch,
    input  multi
  );

  modport slave (
    input  btn,
    input  finish,
    output area,
    output switch,
    output multi
  );

endinterface

// File: rtl/area_select_btn_debounce.sv
// One button: 2-FF synchroniser then a stability counter.
// Ports: clk, reset (sync, high), raw button in, db level out.
module area_select_btn_debounce #(
  parameter int DEBOUNCE_CYC = 50000,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYC - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any agreeing cycle restarts the stability window.
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/area_select.sv
// Turns debounced push-buttons into an area index + strobe.
// Ports: clk, reset (sync, high), bus (slave: btn, finish in; area, switch, multi out).
module area_select
  import area_select_pkg::*;
#(
  parameter int N_BTN        = N_BTN_DEF,
  parameter int AW           = AW_DEF,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         reset,
  area_select_if.slave bus
);

  logic [N_BTN-1:0] db;
  enc_t             enc;
  logic [AW-1:0]    sel;
  logic             many;
  logic             any;
  state_t           state;
  logic             stale;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    area_select_btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (bus.btn[i]),
      .db   (db[i])
    );
  end

  always_comb begin
    enc  = onehot_enc(db);
    sel  = enc.idx;
    any  = (db != '0);
    many = ($countones(db) > 1);
  end

  // stale marks a press that was already down while
  // finish was high; it must be fully released before
  // the next press can be accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      stale      <= 1'b0;
      bus.area   <= '0;
      bus.switch <= 1'b0;
      bus.multi  <= 1'b0;
    end else begin
      bus.switch <= 1'b0;
      bus.multi  <= many;
      stale      <= any && (stale || bus.finish);
      unique case (state)
        IDLE: begin
          if (!bus.finish && !stale && any) begin
            state <= HELD;
            if (enc.ok) begin
              bus.area   <= sel;
              bus.switch <= 1'b1;
            end
          end
        end
        HELD: begin
          if (!any) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
